led_scanner: RTL and testbench

LED_SCANNER -- requirements
Module: led_scanner

---
 rtl/led_scanner.sv | 131 +++++++++++++
 tb/tb_led_scanner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_scanner.sv
// led_scanner: prescaled LED pattern generator with bounce, rotate-up,
// rotate-down and bar-fill modes. The pattern advances once per step
// period; led and step are registered and change together.
module led_scanner #(
    parameter int NUM_LEDS    = 6,
    parameter int STEP_CYCLES = 13_500_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [1:0]          mode,
    input  logic [1:0]          speed,
    input  logic                pause,
    output logic [NUM_LEDS-1:0] led,
    output logic                step,
    output logic                dir
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam int PW = $clog2(NUM_LEDS);
    localparam logic [PW-1:0]       LAST_POS  = PW'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] RESET_PAT = NUM_LEDS'(1);

    typedef enum logic [1:0] {
        MODE_BOUNCE   = 2'b00,
        MODE_ROT_UP   = 2'b01,
        MODE_ROT_DOWN = 2'b10,
        MODE_BAR      = 2'b11
    } mode_e;

    mode_e                mode_cur;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [PW-1:0]        pos;
    logic [PW-1:0]        pos_next;
    logic                 dir_next;
    logic                 tick;
    logic [31:0]          period;
    logic [31:0]          period_m1;
    logic [NUM_LEDS-1:0]  pat_next;
    logic [NUM_LEDS-1:0]  led_next;

    assign mode_cur = mode_e'(mode);

    // Prescaler: period select, tick decision and next counter value.
    // Periods that shift down to zero are clamped to one step per cycle.
    always_comb begin
        period = 32'(STEP_CYCLES) >> speed;
        if (period == 32'd0) begin
            period = 32'd1;
        end
        period_m1 = period - 32'd1;
        tick      = !pause && (32'(cnt) >= period_m1);
        cnt_next  = cnt;
        if (!pause) begin
            cnt_next = tick ? '0 : cnt + CW'(1);
        end
    end

    // Next position and direction for the current mode, applied only on tick.
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        if (tick) begin
            unique case (mode_cur)
                MODE_BOUNCE: begin
                    if (dir) begin
                        if (pos == LAST_POS) begin
                            pos_next = LAST_POS - PW'(1);
                            dir_next = 1'b0;
                        end else begin
                            pos_next = pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_next = PW'(1);
                            dir_next = 1'b1;
                        end else begin
                            pos_next = pos - PW'(1);
                        end
                    end
                end
                MODE_ROT_UP, MODE_BAR: begin
                    pos_next = (pos == LAST_POS) ? '0 : pos + PW'(1);
                    dir_next = 1'b1;
                end
                MODE_ROT_DOWN: begin
                    pos_next = (pos == '0) ? LAST_POS : pos - PW'(1);
                    dir_next = 1'b0;
                end
                default: begin
                    pos_next = pos;
                    dir_next = dir;
                end
            endcase
        end
    end

    // Pattern for the next position: thermometer in bar mode, one-hot otherwise.
    always_comb begin
        pat_next = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (mode_cur == MODE_BAR) begin
                pat_next[i] = (PW'(i) <= pos_next);
            end else begin
                pat_next[i] = (PW'(i) == pos_next);
            end
        end
        led_next = (ACTIVE_LOW != 0) ? ~pat_next : pat_next;
    end

    // State registers; reset overrides pause, tick and mode.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt  <= '0;
            pos  <= '0;
            dir  <= 1'b1;
            step <= 1'b0;
            led  <= (ACTIVE_LOW != 0) ? ~RESET_PAT : RESET_PAT;
        end else begin
            cnt  <= cnt_next;
            step <= tick;
            if (tick) begin
                pos <= pos_next;
                dir <= dir_next;
                led <= led_next;
            end
        end
    end

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed and randomized checks of led_scanner against an
// arithmetic reference model of position, direction and step timing.
module tb_led_scanner;

    localparam int N  = 6;
    localparam int SC = 4;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         pause   = 1'b0;
    logic [1:0]   mode    = 2'b00;
    logic [1:0]   speed   = 2'b00;
    logic [N-1:0] led;
    logic         step;
    logic         dir;

    int checks = 0;
    int errors = 0;

    int           m_cnt  = 0;
    int           m_pos  = 0;
    logic         m_dir  = 1'b1;
    logic         m_step = 1'b0;
    logic [N-1:0] m_led  = 6'b111110;

    led_scanner #(
        .NUM_LEDS   (N),
        .STEP_CYCLES(SC),
        .ACTIVE_LOW (1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .mode   (mode),
        .speed  (speed),
        .pause  (pause),
        .led    (led),
        .step   (step),
        .dir    (dir)
    );

    always #5 sys_clk = ~sys_clk;

    // Active-low drive for a lit position (single LED or bar 0..p).
    function automatic logic [N-1:0] model_led(input int p, input bit bar);
        logic [63:0] pat;
        pat = bar ? ((64'd1 << (p + 1)) - 64'd1) : (64'd1 << p);
        return ~pat[N-1:0];
    endfunction

    // Reference behaviour at one rising edge, from the current inputs.
    task automatic model_edge();
        int per;
        if (sys_rst) begin
            m_cnt  = 0;
            m_pos  = 0;
            m_dir  = 1'b1;
            m_step = 1'b0;
            m_led  = model_led(0, 1'b0);
        end else if (pause) begin
            m_step = 1'b0;
        end else begin
            per = SC >> speed;
            if (per < 1) per = 1;
            if (m_cnt >= per - 1) begin
                m_cnt = 0;
                case (mode)
                    2'b00: begin
                        if (m_dir) begin
                            if (m_pos == N - 1) begin m_pos = N - 2; m_dir = 1'b0; end
                            else m_pos = m_pos + 1;
                        end else begin
                            if (m_pos == 0) begin m_pos = 1; m_dir = 1'b1; end
                            else m_pos = m_pos - 1;
                        end
                    end
                    2'b10: begin m_pos = (m_pos + N - 1) % N; m_dir = 1'b0; end
                    default: begin m_pos = (m_pos + 1) % N; m_dir = 1'b1; end
                endcase
                m_step = 1'b1;
                m_led  = model_led(m_pos, mode == 2'b11);
            end else begin
                m_cnt  = m_cnt + 1;
                m_step = 1'b0;
            end
        end
    endtask

    task automatic tick_clk();
        @(posedge sys_clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; pause = 1'b0; mode = 2'b00; speed = 2'b00;
        tick_clk(); tick_clk();
        checks++; if (led !== 6'b111110) begin errors++; $display("FAIL reset_led got %b want %b", led, 6'b111110); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b want 0", step); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b want 1", dir); end
        checks++; if (int'(dut.cnt) != 0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.cnt); end
        sys_rst = 1'b0;
    endtask

    task automatic test_bounce();
        logic [N-1:0] exp_seq [11];
        logic         exp_dir [11];
        int n = 0;
        exp_seq = '{6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111, 6'b101111,
                    6'b110111, 6'b111011, 6'b111101, 6'b111110, 6'b111101};
        exp_dir = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        sys_rst = 1'b1; mode = 2'b00; tick_clk(); sys_rst = 1'b0;
        for (int i = 0; i < 44; i++) begin
            tick_clk();
            checks++; if (step !== m_step) begin errors++; $display("FAIL bounce_step cyc %0d got %b want %b", i, step, m_step); end
            checks++; if (led !== m_led) begin errors++; $display("FAIL bounce_led cyc %0d got %b want %b", i, led, m_led); end
            checks++; if (step !== ((i % 4) == 3)) begin errors++; $display("FAIL bounce_period cyc %0d got %b", i, step); end
            if (step === 1'b1 && n < 11) begin
                checks++; if (led !== exp_seq[n]) begin errors++; $display("FAIL bounce_seq step %0d got %b want %b", n, led, exp_seq[n]); end
                checks++; if (dir !== exp_dir[n]) begin errors++; $display("FAIL bounce_dir step %0d got %b want %b", n, dir, exp_dir[n]); end
                n++;
            end
        end
        checks++; if (n != 11) begin errors++; $display("FAIL bounce_count got %0d want 11", n); end
    endtask

    task automatic test_rotate();
        int n = 0;
        int cyc = 0;
        sys_rst = 1'b1; tick_clk(); sys_rst = 1'b0; mode = 2'b01;
        while (n < 6 && cyc < 60) begin
            tick_clk(); cyc++;
            checks++; if (led !== m_led || step !== m_step || dir !== m_dir) begin errors++; $display("FAIL rotup_model got %b/%b/%b want %b/%b/%b", led, step, dir, m_led, m_step, m_dir); end
            if (step === 1'b1) begin
                n++;
                if (n == 5) begin checks++; if (led !== 6'b011111) begin errors++; $display("FAIL rotup_top got %b want 011111", led); end end
                if (n == 6) begin checks++; if (led !== 6'b111110) begin errors++; $display("FAIL rotup_wrap got %b want 111110", led); end end
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL rotup_timeout got %0d steps want 6", n); end
        mode = 2'b10; cyc = 0;
        do begin tick_clk(); cyc++; end while (step !== 1'b1 && cyc < 20);
        checks++; if (led !== 6'b011111) begin errors++; $display("FAIL rotdn_wrap got %b want 011111", led); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rotdn_dir got %b want 0", dir); end
    endtask

    task automatic test_bar();
        logic [N-1:0] exp_seq [6];
        int n = 0;
        int cyc = 0;
        exp_seq = '{6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000, 6'b111110};
        sys_rst = 1'b1; tick_clk(); sys_rst = 1'b0; mode = 2'b11;
        checks++; if (led !== 6'b111110) begin errors++; $display("FAIL bar_init got %b want 111110", led); end
        while (n < 6 && cyc < 60) begin
            tick_clk(); cyc++;
            if (step === 1'b1) begin
                checks++; if (led !== exp_seq[n]) begin errors++; $display("FAIL bar_seq step %0d got %b want %b", n, led, exp_seq[n]); end
                checks++; if (dir !== 1'b1) begin errors++; $display("FAIL bar_dir got %b want 1", dir); end
                n++;
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL bar_timeout got %0d steps want 6", n); end
    endtask

    task automatic test_pause();
        logic [N-1:0] held;
        int cyc = 0;
        sys_rst = 1'b1; tick_clk(); sys_rst = 1'b0; mode = 2'b00; speed = 2'b00;
        tick_clk(); tick_clk(); tick_clk(); tick_clk(); tick_clk(); tick_clk();
        while (m_cnt != 2 && cyc < 10) begin tick_clk(); cyc++; end
        pause = 1'b1;
        held  = led;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            checks++; if (step !== 1'b0) begin errors++; $display("FAIL pause_step cyc %0d got %b want 0", i, step); end
            checks++; if (led !== held) begin errors++; $display("FAIL pause_led cyc %0d got %b want %b", i, led, held); end
            checks++; if (int'(dut.cnt) != 2) begin errors++; $display("FAIL pause_cnt cyc %0d got %0d want 2", i, dut.cnt); end
        end
        pause = 1'b0; cyc = 0;
        do begin tick_clk(); cyc++; end while (step !== 1'b1 && cyc < 10);
        checks++; if (cyc != 2) begin errors++; $display("FAIL pause_resume got %0d cycles want 2", cyc); end
        checks++; if (led !== m_led) begin errors++; $display("FAIL pause_led_after got %b want %b", led, m_led); end
    endtask

    task automatic test_speed();
        int cyc = 0;
        sys_rst = 1'b1; tick_clk(); sys_rst = 1'b0; mode = 2'b00; speed = 2'b00;
        while (m_cnt != 2 && cyc < 10) begin tick_clk(); cyc++; end
        speed = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick_clk();
            checks++; if (step !== 1'b1) begin errors++; $display("FAIL speed_step cyc %0d got %b want 1", i, step); end
            checks++; if (led !== m_led) begin errors++; $display("FAIL speed_led cyc %0d got %b want %b", i, led, m_led); end
        end
        speed = 2'b00;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        sys_rst = 1'b1; tick_clk(); sys_rst = 1'b0; mode = 2'b00; speed = 2'b00;
        while (!(m_pos == 4 && m_dir == 1'b0) && cyc < 100) begin tick_clk(); cyc++; end
        checks++; if (cyc >= 100) begin errors++; $display("FAIL rstmid_timeout got %0d cycles", cyc); end
        tick_clk();
        pause = 1'b1; tick_clk();
        sys_rst = 1'b1; tick_clk(); sys_rst = 1'b0;
        checks++; if (led !== 6'b111110) begin errors++; $display("FAIL rstmid_led got %b want 111110", led); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL rstmid_dir got %b want 1", dir); end
        checks++; if (int'(dut.cnt) != 0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", dut.cnt); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL rstmid_step got %b want 0", step); end
        pause = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
            pause   = ($urandom_range(0, 9) == 0);
            sys_rst = ($urandom_range(0, 99) == 0);
            tick_clk();
            checks++; if (led !== m_led) begin errors++; $display("FAIL rand_led cyc %0d got %b want %b", i, led, m_led); end
            checks++; if (step !== m_step) begin errors++; $display("FAIL rand_step cyc %0d got %b want %b", i, step, m_step); end
            checks++; if (dir !== m_dir) begin errors++; $display("FAIL rand_dir cyc %0d got %b want %b", i, dir, m_dir); end
        end
        sys_rst = 1'b0; pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_rotate();
        test_bar();
        test_pause();
        test_speed();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
